// File: rtl/audio_pkg.sv
// Shared constants and elaboration-time helpers for the TDM/I2S audio master.
package audio_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_TDM = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Serial bits per frame (F).
  function automatic int frame_bits(input int nch, input int slot_w);
    return nch * slot_w;
  endfunction

  // Width of a 0..DEPTH occupancy count.
  function automatic int level_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead frame FIFO; pointers carry one extra wrap bit so
// full/empty/level fall straight out of the pointer difference.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_rd,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_level
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_wr && !o_full;
  assign w_rd = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;

endmodule

// File: rtl/tdm_audio_master.sv
// N-channel I2S/TDM serial audio master: frame FIFO, clock-enable BCLK divider,
// frame-wide output shift register and sticky underrun/overflow flags.
module tdm_audio_master
  import audio_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int BCLK_DIV     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              mode_tdm,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    frame_in,
  input  logic                              write_frame,
  output logic                              full,
  output logic [clog2(FIFO_DEPTH):0]        level,
  output logic                              underrun,
  output logic                              overflow,
  input  logic                              clear_flags,
  output logic                              bclk,
  output logic                              lrclk,
  output logic                              sdata
);
  localparam int F       = frame_bits(NUM_CH, SLOT_WIDTH);
  localparam int FW      = NUM_CH * SAMPLE_WIDTH;
  localparam int DW      = (clog2(BCLK_DIV) < 1) ? 1 : clog2(BCLK_DIV);
  localparam int PW      = clog2(F);
  localparam int LEVEL_W = level_w(FIFO_DEPTH);

  logic [DW-1:0]      r_div_cnt;
  logic [PW-1:0]      r_pos;
  logic [F-1:0]       r_sr;
  logic               r_run;
  logic               r_tdm;
  logic               r_sdata;
  logic               r_lrclk;
  logic               r_underrun;
  logic               r_overflow;

  logic [FW-1:0]      w_head;
  logic               w_full;
  logic               w_empty;
  logic [LEVEL_W-1:0] w_level;
  logic [F-1:0]       w_load;
  logic               w_wrap;
  logic               w_start;
  logic [PW-1:0]      w_pos_nxt;
  logic               w_bound;
  logic               w_tdm_nxt;
  logic               w_pop;
  logic               w_lr_nxt;

  audio_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_wr    (write_frame),
    .i_wdata (frame_in),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Left-justify each sample in its slot; ch0 lands in the top slot.
  always_comb begin
    w_load = '0;
    if (!w_empty) begin
      for (int c = 0; c < NUM_CH; c++)
        w_load[F-1-c*SLOT_WIDTH -: SAMPLE_WIDTH] = w_head[FW-1-c*SAMPLE_WIDTH -: SAMPLE_WIDTH];
    end
  end

  // A BCLK period starts on the first running edge or when div_cnt wraps;
  // registered sdata/lrclk then change together with the bclk fall.
  assign w_wrap    = (r_div_cnt == DW'(BCLK_DIV - 1));
  assign w_start   = enable && (!r_run || w_wrap);
  assign w_pos_nxt = (!r_run || r_pos == PW'(F - 1)) ? '0 : r_pos + 1'b1;
  assign w_bound   = w_start && (w_pos_nxt == '0);
  assign w_tdm_nxt = w_bound ? mode_tdm : r_tdm;
  assign w_pop     = w_bound && !w_empty;
  assign w_lr_nxt  = (w_tdm_nxt == MODE_TDM) ? (w_pos_nxt == '0) : (w_pos_nxt >= PW'(F / 2));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_run     <= 1'b0;
      r_div_cnt <= '0;
      r_pos     <= '0;
      r_sr      <= '0;
      r_sdata   <= 1'b0;
      r_lrclk   <= 1'b0;
      if (reset) r_tdm <= MODE_I2S;
    end else begin
      r_run     <= 1'b1;
      r_div_cnt <= (!r_run || w_wrap) ? '0 : r_div_cnt + 1'b1;
      if (w_start) begin
        r_pos   <= w_pos_nxt;
        r_tdm   <= w_tdm_nxt;
        r_sdata <= r_sr[F-1];
        r_lrclk <= w_lr_nxt;
        r_sr    <= w_bound ? w_load : {r_sr[F-2:0], 1'b0};
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_bound && w_empty) r_underrun <= 1'b1;
      else if (clear_flags)   r_underrun <= 1'b0;
      if (write_frame && w_full) r_overflow <= 1'b1;
      else if (clear_flags)      r_overflow <= 1'b0;
    end
  end

  assign bclk     = (r_div_cnt >= DW'(BCLK_DIV / 2));
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign full     = w_full;
  assign level    = w_level;
  assign underrun = r_underrun;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_tdm_audio_master.sv
// Scoreboard bench: writers queue expected serial frames, a bclk-edge monitor
// reassembles each frame and its lrclk pattern and compares against the queue.
module tb_tdm_audio_master;
  localparam int F = 64;
  localparam logic [63:0] I2S_LR = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] TDM_LR = 64'h80000000_00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mode_tdm = 1'b0;
  logic        write_frame = 1'b0;
  logic        clear_flags = 1'b0;
  logic [47:0] frame_in = '0;
  logic        full, underrun, overflow, bclk, lrclk, sdata;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_bad = 0;
  int pos0_cnt = 0;
  int cyc = 0;
  int p0_cyc = 0;
  logic [63:0] exp_q[$];

  tdm_audio_master #(
    .NUM_CH(2), .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(4), .BCLK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_tdm(mode_tdm),
    .frame_in(frame_in), .write_frame(write_frame), .full(full), .level(level),
    .underrun(underrun), .overflow(overflow), .clear_flags(clear_flags),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: samples on each bclk rise, i.e. where the codec samples.
  initial begin : monitor
    int          mpos;
    bit          have_cur;
    bit          cur_tdm;
    bit          prev_bclk;
    logic [63:0] cur_exp, shw, lrw;
    mpos = -1; have_cur = 0; cur_tdm = 0; prev_bclk = 0;
    cur_exp = '0; shw = '0; lrw = '0;
    forever begin
      @(negedge clk);
      if (reset || !enable) begin
        mpos = -1; have_cur = 0; prev_bclk = 0;
      end else begin
        if (bclk && !prev_bclk) begin
          mpos = (mpos == F - 1) ? 0 : mpos + 1;
          if (mpos == 0) begin
            if (have_cur) chk("frame_data", {shw[62:0], sdata}, cur_exp);
            cur_exp  = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
            cur_tdm  = mode_tdm;
            have_cur = 1;
            shw      = '0;
            lrw      = '0;
            pos0_cnt++;
            p0_cyc   = cyc;
          end else begin
            shw = {shw[62:0], sdata};
          end
          lrw = {lrw[62:0], lrclk};
          if (mpos == F - 1) chk("lrclk_pattern", lrw, cur_tdm ? TDM_LR : I2S_LR);
        end
        prev_bclk = bclk;
      end
    end
  end

  task automatic wait_pos0();
    int c0, k;
    c0 = pos0_cnt; k = 0;
    while (pos0_cnt == c0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (pos0_cnt == c0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_pos0: no frame start within %0d cycles", k);
    end
  endtask

  // Returns just after the posedge preceding the next frame boundary, so
  // inputs driven now are sampled on the boundary edge itself.
  task automatic arm_boundary();
    int tgt, k;
    tgt = p0_cyc + 253; k = 0;
    while (tgt <= cyc) tgt += 256;
    while (cyc != tgt && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    if (cyc != tgt) begin
      n_cmp++; n_bad++;
      $display("FAIL arm_boundary: cycle %0d, wanted %0d", cyc, tgt);
    end
  endtask

  task automatic wr(input logic [47:0] d, input logic [63:0] e, input bit push);
    frame_in = d; write_frame = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    write_frame = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) wait_pos0();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    wait_pos0();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", {61'd0, bclk, lrclk, sdata}, 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_flags", {61'd0, full, underrun, overflow}, 64'd0);
    reset = 1'b0;

    // Fill while disabled; fifth write is dropped
    wr(48'hA5A5A5_123456, 64'hA5A5A500_12345600, 1); chk("fill_lvl1", 64'(level), 64'd1);
    wr(48'h111111_222222, 64'h11111100_22222200, 1); chk("fill_lvl2", 64'(level), 64'd2);
    wr(48'hFFFFFF_000001, 64'hFFFFFF00_00000100, 1); chk("fill_lvl3", 64'(level), 64'd3);
    wr(48'h800000_7FFFFF, 64'h80000000_7FFFFF00, 1); chk("fill_lvl4", 64'(level), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("pre_ovf", 64'(overflow), 64'd0);
    wr(48'hDEAD00_BEEF00, 64'h0, 0);
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_set", 64'(overflow), 64'd1);
    pulse_clear();
    chk("ovf_clear", 64'(overflow), 64'd0);

    // I2S playback of the four frames, then underrun
    enable = 1'b1;
    wait_pos0();
    chk("run_lvl3", 64'(level), 64'd3);
    repeat (3) wait_pos0();
    chk("run_lvl0", 64'(level), 64'd0);
    chk("no_underrun_yet", 64'(underrun), 64'd0);
    wait_pos0();
    chk("underrun_set", 64'(underrun), 64'd1);

    // Clear, then clear coinciding with a fresh underrun
    pulse_clear();
    chk("underrun_clear", 64'(underrun), 64'd0);
    arm_boundary();
    clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
    chk("underrun_set_wins", 64'(underrun), 64'd1);

    // Write+pop at level 2, then write-while-full with pop
    wait_pos0();
    wr(48'h010203_040506, 64'h01020300_04050600, 1);
    wr(48'h0A0B0C_0D0E0F, 64'h0A0B0C00_0D0E0F00, 1);
    chk("lvl2_before", 64'(level), 64'd2);
    arm_boundary();
    wr(48'hC0FFEE_FACADE, 64'hC0FFEE00_FACADE00, 1);
    chk("wr_pop_lvl", 64'(level), 64'd2);
    wait_pos0();
    wr(48'h135790_246800, 64'h13579000_24680000, 1);
    wr(48'hABCDEF_FEDCBA, 64'hABCDEF00_FEDCBA00, 1);
    chk("full_again", {60'd0, full, level}, {60'd0, 1'b1, 3'd4});
    arm_boundary();
    wr(48'h555555_AAAAAA, 64'h0, 0);
    chk("full_pop_lvl", {60'd0, full, level}, {60'd0, 1'b0, 3'd3});
    chk("full_pop_ovf", 64'(overflow), 64'd1);
    drain();

    // TDM frame; mode change mid-frame only applies at the next frame
    wait_pos0();
    mode_tdm = 1'b1;
    wr(48'h800001_000000, 64'h80000100_00000000, 1);
    wait_pos0();
    mode_tdm = 1'b0;
    repeat (2) wait_pos0();

    // Reset at pos 40 with a frame queued and both flags set
    wait_pos0();
    wr(48'h777777_888888, 64'h0, 0);
    chk("pre_rst_state", {59'd0, underrun, overflow, level}, {59'd0, 1'b1, 1'b1, 3'd1});
    while (cyc < p0_cyc + 158) begin @(posedge clk); #1; end
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_pins", {61'd0, bclk, lrclk, sdata}, 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_flags", {62'd0, underrun, overflow}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    wait_pos0();
    wr(48'h5A5A5A_3C3C3C, 64'h5A5A5A00_3C3C3C00, 1);
    drain();
    chk("final_underrun", 64'(underrun), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/tdm_audio_master.md
Name: tdm_audio_master

Overview:
Parametrised successor to the two-channel I2S transmitter feeding the ADAU codec. It generalises to N channels, configurable sample and slot width, and a configurable frame FIFO depth. It selects at run time between I2S and TDM framing. It runs entirely in the SoC clock domain, generating BCLK and LRCLK/FSYNC by clock-enable division, and sits between the Wishbone bus logic (frame producer) and the codec serial pins.

Parameters:
NUM_CH, 2, channel count; even, 2..8.
SAMPLE_WIDTH, 24, bits per sample; must be ≤ SLOT_WIDTH.
SLOT_WIDTH, 32, BCLK periods per channel slot.
FIFO_DEPTH, 16, frames buffered; power of 2, ≥ 2.
BCLK_DIV, 8, clk cycles per BCLK period; even, ≥ 2.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = serial interface running.
mode_tdm  in  1  0 = I2S framing, 1 = TDM framing.
frame_in  in  NUM_CH*SAMPLE_WIDTH  one frame; ch0 in the MSBs.
write_frame  in  1  push frame_in this cycle.
full  out  1  FIFO holds FIFO_DEPTH frames.
level  out  clog2(FIFO_DEPTH)+1  frames currently stored.
underrun  out  1  sticky: a frame boundary occurred with the FIFO empty.
overflow  out  1  sticky: write_frame was asserted while full.
clear_flags  in  1  clears underrun and overflow.
bclk  out  1  serial bit clock.
lrclk  out  1  word select (I2S) or frame sync (TDM).
sdata  out  1  serial data, MSB first.

Behaviour:
- Reset: bclk, lrclk, sdata, full, underrun and overflow are 0; level is 0; FIFO is empty; all counters are 0. Reset mid-frame aborts the frame immediately.
- Frame length F = NUM_CH*SLOT_WIDTH BCLK periods. Counters:
  - div_cnt runs 0..BCLK_DIV-1.
  - pos runs 0..F-1 and advances when div_cnt wraps.
- BCLK: bclk is 0 for div_cnt < BCLK_DIV/2 and 1 otherwise. Each period starts on a falling edge at div_cnt = 0, where sdata and lrclk update. The codec samples on the rising edge.
- Shift register SR is F bits wide. Each slot carries its sample left-justified, MSB first, with the remaining SLOT_WIDTH-SAMPLE_WIDTH bits zero.
- At the start of each period, sdata <= SR[F-1] and SR shifts left. This yields a 1-BCLK data delay in both modes.
- At the start of pos = 0, SR is loaded after its MSB is emitted, from one of two sources:
  - FIFO not empty: the head frame is popped (show-ahead read) and loaded.
  - FIFO empty: all-zero data is loaded and underrun is set.
- Hence the MSB of ch0 appears during pos = 1, and the last bit of the previous frame appears during pos = 0.
- lrclk: in I2S mode, lrclk = 1 iff pos ≥ F/2. In TDM mode, lrclk = 1 iff pos = 0 (one-BCLK pulse).
- mode_tdm is sampled only at the start of pos = 0; changes mid-frame take effect at the next frame.
- enable = 0: div_cnt and pos are held at 0; bclk, lrclk and sdata are driven 0; no FIFO pops; writes are still accepted. The first cycle with enable = 1 begins pos = 0 with div_cnt = 0.
- Writes: a write occurs iff write_frame && !full.
  - write_frame && full drops the frame and sets overflow, even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle leave level unchanged.
  - A write to an empty FIFO in the same cycle as a boundary pop gives underrun (the frame is not visible until the next cycle), and the written frame is stored.
- full and level are registered, reflecting state after the current edge.
- If clear_flags is asserted in the same cycle as a new underrun or overflow event, the flag ends set (set wins).
- Latency: a written frame appears no earlier than the next pos = 0 boundary plus 1 BCLK.

Decomposition:
- Package audio_pkg holds:
  - MODE_I2S = 0 and MODE_TDM = 1;
  - the clog2 function;
  - derived localparams: frame bits F and LEVEL_W.
- Sub-module audio_frame_fifo: a synchronous show-ahead FIFO, parametrised by width and depth. It provides full, empty and level, using wrap-around pointers with one extra bit.
- The serializer, dividers and flag logic live in the top-level block.

Test Plan:
- Config NUM_CH=2, SAMPLE_WIDTH=24, SLOT_WIDTH=32, BCLK_DIV=4 (F = 64, 256 clk per frame), I2S mode: write frame {24'hA5A5A5, 24'h123456}, enable → during pos 1..24 sdata is A5A5A5 MSB first, pos 25..32 are 0, then 123456 occupies pos 33..56; lrclk is 0 for pos 0..31 and 1 for pos 32..63.
- TDM, NUM_CH=4: write 4-channel frame {ch0=24'h800001, ch1=ch2=ch3=0} → lrclk high only during pos = 0 of each 128-period frame; MSB of ch0 during pos 1, its LSB during pos 24.
- Enable with an empty FIFO → sdata stays 0, underrun = 1 after the first boundary; clear_flags pulse → 0; an underrun event coinciding with clear_flags → remains 1.
- FIFO_DEPTH=4, enable = 0: 5 consecutive writes → level goes 1,2,3,4, full = 1, the 5th is dropped and overflow = 1; enable → 4 frames are output in order, then underrun is set.
- Write and pop in the same cycle at level = 2 → level stays 2; write while full with a simultaneous pop → level drops to 3 and overflow = 1.
- Assert reset during pos = 40 → the next cycle shows bclk, lrclk and sdata at 0, level at 0 and flags at 0; after release with enable = 1, framing restarts at pos = 0.
